writeback_unit: RTL

//  Write side of the integer register file. Merges the ALU result stream and the load-data stream.

---
 rtl/writeback_unit.sv | 134 +++++++++++++
 1 files changed

// File: rtl/writeback_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : writeback_unit                                             |
// | Description : Register-file write port arbiter. Merges ALU results and   |
// |               extended load data; parks colliding ALU results.           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module writeback_unit #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [REG_AW-1:0] alu_rd,
   input  logic [XLEN-1:0]   alu_result,
   input  logic              ld_valid,
   input  logic [REG_AW-1:0] ld_rd,
   input  logic [XLEN-1:0]   ld_data,
   input  logic [2:0]        ld_funct3,
   input  logic [1:0]        ld_addr_lo,
   output logic              rf_wr_en,
   output logic [REG_AW-1:0] rf_rd,
   output logic [XLEN-1:0]   rf_result,
   output logic              pend_valid,
   output logic [REG_AW-1:0] pend_rd,
   output logic              ld_err
);

   localparam logic [2:0] c_F3_LB  = 3'd0;
   localparam logic [2:0] c_F3_LH  = 3'd1;
   localparam logic [2:0] c_F3_LW  = 3'd2;
   localparam logic [2:0] c_F3_LBU = 3'd4;
   localparam logic [2:0] c_F3_LHU = 3'd5;

   logic              r_pend_valid;
   logic [REG_AW-1:0] r_pend_rd;
   logic [XLEN-1:0]   r_pend_result;

   logic              w_alu_acc;
   logic              w_alu_keep;
   logic [7:0]        w_byte;
   logic [15:0]       w_half;
   logic [XLEN-1:0]   w_ld_result;
   logic              w_ld_bad;
   logic              w_sel_valid;
   logic [REG_AW-1:0] w_sel_rd;
   logic [XLEN-1:0]   w_sel_result;

   assign alu_ready  = !r_pend_valid;
   assign pend_valid = r_pend_valid;
   assign pend_rd    = r_pend_rd;
   assign w_alu_acc  = alu_valid && alu_ready;
   // rd==0 results are accepted but discarded, so they never occupy the buffer
   assign w_alu_keep = w_alu_acc && (alu_rd != '0);

   assign w_byte = ld_data[8*ld_addr_lo +: 8];
   assign w_half = ld_addr_lo[1] ? ld_data[31:16] : ld_data[15:0];

   always_comb begin
      w_ld_result = '0;
      w_ld_bad    = 1'b0;
      case (ld_funct3)
         c_F3_LB:  w_ld_result = {{(XLEN-8){w_byte[7]}}, w_byte};
         c_F3_LBU: w_ld_result = {{(XLEN-8){1'b0}}, w_byte};
         c_F3_LH: begin
            w_ld_result = {{(XLEN-16){w_half[15]}}, w_half};
            w_ld_bad    = ld_addr_lo[0];
         end
         c_F3_LHU: begin
            w_ld_result = {{(XLEN-16){1'b0}}, w_half};
            w_ld_bad    = ld_addr_lo[0];
         end
         c_F3_LW: begin
            w_ld_result = ld_data;
            w_ld_bad    = (ld_addr_lo != 2'd0);
         end
         default: w_ld_bad = 1'b1;
      endcase
   end

   // Priority: load, then buffered ALU result, then fresh ALU result
   always_comb begin
      w_sel_valid  = 1'b0;
      w_sel_rd     = '0;
      w_sel_result = '0;
      if (ld_valid) begin
         w_sel_valid  = 1'b1;
         w_sel_rd     = ld_rd;
         w_sel_result = w_ld_result;
      end else if (r_pend_valid) begin
         w_sel_valid  = 1'b1;
         w_sel_rd     = r_pend_rd;
         w_sel_result = r_pend_result;
      end else if (w_alu_keep) begin
         w_sel_valid  = 1'b1;
         w_sel_rd     = alu_rd;
         w_sel_result = alu_result;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_wr_en  <= 1'b0;
         rf_rd     <= '0;
         rf_result <= '0;
         ld_err    <= 1'b0;
      end else begin
         rf_wr_en <= w_sel_valid && (w_sel_rd != '0);
         ld_err   <= ld_valid && w_ld_bad;
         if (w_sel_valid) begin
            rf_rd     <= w_sel_rd;
            rf_result <= w_sel_result;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pend_valid  <= 1'b0;
         r_pend_rd     <= '0;
         r_pend_result <= '0;
      end else if (ld_valid && w_alu_keep) begin
         r_pend_valid  <= 1'b1;
         r_pend_rd     <= alu_rd;
         r_pend_result <= alu_result;
      end else if (!ld_valid && r_pend_valid) begin
         r_pend_valid  <= 1'b0;
      end
   end

endmodule
`default_nettype wire
